// File: rtl/baud_tick_gen_pkg.sv
// Shared constants for the programmable baud / tick divider.
// Holds the default widths, the minimum divisor and common baud divisors.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF   = 28;
    localparam int unsigned DIV_MIN     = 1;
    localparam int unsigned DIV_9600    = 10417;
    localparam int unsigned DIV_115200  = 868;
    localparam int unsigned OS_RATE_DEF = 16;

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control / status bundle between a divisor programmer and baud_tick_gen.
// master: drives enable, div_in, div_load; slave: drives busy, err, ticks.
// os_tick exists only when CLK_DIV_OS_EN is defined.
interface baud_tick_gen_if
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             enable;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic             div_err;
    logic             tick;
    logic             clk_out;
`ifdef CLK_DIV_OS_EN
    logic             os_tick;
`endif

    modport master (
        output enable,
        output div_in,
        output div_load,
`ifdef CLK_DIV_OS_EN
        input  os_tick,
`endif
        input  div_busy,
        input  div_err,
        input  tick,
        input  clk_out
    );

    modport slave (
        input  enable,
        input  div_in,
        input  div_load,
`ifdef CLK_DIV_OS_EN
        output os_tick,
`endif
        output div_busy,
        output div_err,
        output tick,
        output clk_out
    );

endinterface

// File: rtl/baud_tick_gen_os_cnt.sv
// Oversample sub-counter 0..OS_RATE-1, advanced once per base period.
// Ports: clk_in, rst, i_adv (advance), i_clr (restart), o_last, o_half.
module clk_div_os_cnt #(
    parameter int unsigned OS_RATE = 16
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_adv,
    input  logic i_clr,
    output logic o_last,
    output logic o_half
);
    localparam int unsigned W =
        (OS_RATE > 1) ? $clog2(OS_RATE) : 1;

    logic [W-1:0] r_os_cnt;

    assign o_last = (r_os_cnt == W'(OS_RATE - 1));
    assign o_half = (r_os_cnt < W'(OS_RATE >> 1));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_os_cnt <= '0;
        end else if (i_clr) begin
            r_os_cnt <= '0;
        end else if (i_adv) begin
            if (o_last) begin
                r_os_cnt <= '0;
            end else begin
                r_os_cnt <= r_os_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Runtime-programmable divider: 1-cycle tick every div_act cycles plus a
// registered divided clock. Divisor reload is shadowed and committed at a
// period boundary. Ports: clk_in, rst (sync, active high), bus (slave).
// Optional oversampling stage enabled by macro CLK_DIV_OS_EN.
module baud_tick_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DIV_115200,
    parameter int unsigned OS_RATE     = OS_RATE_DEF
) (
    input  logic            clk_in,
    input  logic            rst,
    baud_tick_gen_if.slave  bus
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_busy;
    logic             r_err;
    logic             r_tick;
    logic             r_clk_out;

    logic [CNT_W-1:0] w_lim;
    logic             w_last;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_wrap_main;
    logic             w_wrap;
    logic             w_idle_commit;
    logic             w_os_last;
    logic             w_half;

    // div_act is never 0, so the subtraction cannot underflow
    assign w_lim       = r_div_act - 1'b1;
    // >= also catches a count left out of range by a shrink
    assign w_last      = (r_cnt >= w_lim);
    assign w_load_ok   = bus.div_load &&
                         (bus.div_in >= CNT_W'(DIV_MIN));
    assign w_load_bad  = bus.div_load && !w_load_ok;
    assign w_wrap_main = bus.enable && w_last;
    assign w_wrap      = w_wrap_main && w_os_last;
    assign w_idle_commit = !w_load_ok && r_busy &&
                           !bus.enable;

`ifdef CLK_DIV_OS_EN
    logic w_os_half;
    logic r_os_tick;

    clk_div_os_cnt #(
        .OS_RATE (OS_RATE)
    ) u_os_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .i_adv  (w_wrap_main),
        .i_clr  (w_idle_commit),
        .o_last (w_os_last),
        .o_half (w_os_half)
    );

    assign w_half = w_os_half;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_os_tick <= 1'b0;
        end else begin
            r_os_tick <= w_wrap_main;
        end
    end

    assign bus.os_tick = r_os_tick;
`else
    assign w_os_last = 1'b1;
    assign w_half    = (r_cnt < (r_div_act >> 1));
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= CNT_W'(DEFAULT_DIV);
            r_div_pend <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
        end else begin
            r_err <= w_load_bad;

            if (bus.enable) begin
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_tick    <= w_wrap;
                r_clk_out <= w_half;
            end else begin
                r_tick <= 1'b0;
            end

            // a load landing on a wrap takes effect at that wrap
            if (w_load_ok && w_wrap) begin
                r_div_act <= bus.div_in;
                r_busy    <= 1'b0;
            end else if (w_load_ok) begin
                r_div_pend <= bus.div_in;
                r_busy     <= 1'b1;
            end else if (r_busy && w_wrap) begin
                r_div_act <= r_div_pend;
                r_busy    <= 1'b0;
            end else if (w_idle_commit) begin
                r_div_act <= r_div_pend;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
            end
        end
    end

    assign bus.div_busy = r_busy;
    assign bus.div_err  = r_err;
    assign bus.tick     = r_tick;
    assign bus.clk_out  = r_clk_out;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: divisor table plus reload corner cases.
module tb_baud_tick_gen;
    import clk_div_pkg::*;

    typedef struct {
        logic [27:0] div;
        int          per;
        int          hi;
        logic [7:0]  pat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    baud_tick_gen_if #(.CNT_W(CNT_W_DEF)) bus ();

    baud_tick_gen #(
        .CNT_W       (CNT_W_DEF),
        .DEFAULT_DIV (DIV_115200),
        .OS_RATE     (OS_RATE_DEF)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d",
                     nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [27:0] v);
        bus.div_in   = v;
        bus.div_load = 1'b1;
        cyc();
        bus.div_load = 1'b0;
    endtask

    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick && n < lim);
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (bus.div_busy && k < lim) begin
            cyc();
            k++;
        end
        chk("commit", 32'(bus.div_busy), 0);
    endtask

    task automatic measure(input int lim, output int per,
                           output int hi,
                           output logic [7:0] pat);
        per = 0;
        hi  = 0;
        pat = '0;
        do begin
            cyc();
            per++;
            hi += int'(bus.clk_out);
            pat = {pat[6:0], bus.clk_out};
        end while (!bus.tick && per < lim);
    endtask

    initial begin
        vec_t       tbl [6];
        int         n, per, hi;
        logic [7:0] pat;
        logic       ok;
        logic       hold;

        tbl[0] = '{28'd4, 4, 2, 8'b0000_1100};
        tbl[1] = '{28'd5, 5, 2, 8'b0001_1000};
        tbl[2] = '{28'd2, 2, 1, 8'b0000_0010};
        tbl[3] = '{28'd7, 7, 3, 8'b0111_0000};
        tbl[4] = '{28'd1, 1, 0, 8'b0000_0000};
        tbl[5] = '{28'd3, 3, 1, 8'b0000_0100};

        bus.enable   = 1'b0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
        rst          = 1'b1;
        repeat (3) cyc();
        chk("rst tick", 32'(bus.tick), 0);
        chk("rst clk_out", 32'(bus.clk_out), 0);
        chk("rst busy", 32'(bus.div_busy), 0);
        chk("rst err", 32'(bus.div_err), 0);
        rst        = 1'b0;
        bus.enable = 1'b1;

`ifdef CLK_DIV_OS_EN
        chk("rst os_tick", 32'(bus.os_tick), 0);
        load(28'd2);
        wait_idle(20000);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.os_tick && n < 100);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (!bus.os_tick && n < 100);
            chk("os period", n, 2);
        end
        wait_tick(200, n);
        measure(200, per, hi, pat);
        chk("os tick period", per, 32);
        chk("os clk_out high", hi, 16);
`else
        wait_tick(2000, n);
        chk("first tick", n, 868);

        foreach (tbl[i]) begin
            load(tbl[i].div);
            wait_idle(2000);
            wait_tick(100, n);
            measure(100, per, hi, pat);
            chk($sformatf("period div=%0d", tbl[i].div),
                per, tbl[i].per);
            chk($sformatf("high div=%0d", tbl[i].div),
                hi, tbl[i].hi);
            chk($sformatf("pattern div=%0d", tbl[i].div),
                32'(pat), 32'(tbl[i].pat));
        end

        load(28'd8);
        wait_idle(100);
        wait_tick(100, n);
        cyc();
        cyc();
        load(28'd3);
        chk("busy after load", 32'(bus.div_busy), 1);
        n  = 0;
        ok = 1'b1;
        do begin
            cyc();
            n++;
            if (!bus.tick && !bus.div_busy) ok = 1'b0;
        end while (!bus.tick && n < 20);
        chk("old period rest", n, 5);
        chk("busy held", 32'(ok), 1);
        chk("busy at wrap", 32'(bus.div_busy), 0);
        measure(20, per, hi, pat);
        chk("period after shrink", per, 3);

        load(28'd9);
        load(28'd6);
        wait_tick(20, n);
        chk("overwrite commit", n, 1);
        measure(20, per, hi, pat);
        chk("last writer wins", per, 6);

        repeat (5) cyc();
        load(28'd4);
        chk("same-cycle tick", 32'(bus.tick), 1);
        chk("same-cycle busy", 32'(bus.div_busy), 0);
        measure(20, per, hi, pat);
        chk("same-cycle period", per, 4);

        load(28'd0);
        chk("err pulse", 32'(bus.div_err), 1);
        chk("err busy", 32'(bus.div_busy), 0);
        cyc();
        chk("err one cycle", 32'(bus.div_err), 0);
        wait_tick(20, n);
        measure(20, per, hi, pat);
        chk("period after err", per, 4);

        load(28'd5);
        load(28'd0);
        chk("err while busy", 32'(bus.div_err), 1);
        chk("busy kept", 32'(bus.div_busy), 1);
        wait_idle(20);
        wait_tick(20, n);
        measure(20, per, hi, pat);
        chk("pend kept", per, 5);

        cyc();
        cyc();
        chk("clk_out pre-freeze", 32'(bus.clk_out), 1);
        hold       = bus.clk_out;
        bus.enable = 1'b0;
        ok         = 1'b1;
        repeat (10) begin
            cyc();
            if (bus.tick || bus.clk_out !== hold) ok = 1'b0;
        end
        chk("frozen", 32'(ok), 1);
        bus.enable = 1'b1;
        wait_tick(20, n);
        chk("resume rest", n, 3);

        bus.enable = 1'b0;
        load(28'd7);
        chk("idle load busy", 32'(bus.div_busy), 1);
        cyc();
        chk("idle commit", 32'(bus.div_busy), 0);
        bus.enable = 1'b1;
        wait_tick(20, n);
        chk("idle commit period", n, 7);

        load(28'd9);
        chk("busy before rst", 32'(bus.div_busy), 1);
        rst = 1'b1;
        cyc();
        chk("mid rst busy", 32'(bus.div_busy), 0);
        chk("mid rst tick", 32'(bus.tick), 0);
        chk("mid rst clk_out", 32'(bus.clk_out), 0);
        rst = 1'b0;
        wait_tick(2000, n);
        chk("tick after rst", n, 868);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
